// File: rtl/dlfloat16_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat16_seq_div
// Brief    : Sequential DLFloat16 divider (restoring, one quotient bit per
//            cycle) with valid/ready handshakes on both sides. Special
//            operands (zero, NaN) short-circuit straight to the result.
//            Truncating rounding, no subnormals.
// Revision : 1.0  initial release
// ============================================================================
module dlfloat16_seq_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_dz,
    output logic        flag_nan
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_DIV  = 2'd1;
    localparam logic [1:0]  S_NORM = 2'd2;
    localparam logic [1:0]  S_DONE = 2'd3;

    localparam logic [3:0]  C_LAST_STEP = 4'd10;    // 11 quotient bits: steps 0..10
    localparam logic [5:0]  C_EXP_ALL1  = 6'h3F;
    localparam logic [8:0]  C_FRAC_ALL1 = 9'h1FF;
    localparam logic [14:0] C_MAX_MAG   = 15'h7DFF;
    localparam logic [15:0] C_NAN       = 16'h7FFF;
    localparam logic signed [7:0] C_EXP_HI = 8'sd62;
    localparam logic signed [7:0] C_EXP_LO = 8'sd1;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [10:0] r_rem;       // partial remainder, always < 2*mb
    logic [10:0] r_quo;       // quotient bits shifted in MSB-first
    logic [9:0]  r_mb;        // divisor mantissa with hidden one
    logic [5:0]  r_ea;
    logic [5:0]  r_eb;
    logic        r_sign;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [15:0] r_result;
    logic        r_ovf;
    logic        r_unf;
    logic        r_dz;
    logic        r_nan;

    // Operand classification, evaluated directly on the input ports
    logic w_a_zero;
    logic w_b_zero;
    logic w_a_nan;
    logic w_b_nan;
    logic w_sign_in;
    logic w_accept;
    logic w_bypass;

    assign w_a_zero  = (a[14:9] == 6'd0);
    assign w_b_zero  = (b[14:9] == 6'd0);
    assign w_a_nan   = (a[14:9] == C_EXP_ALL1) && (a[8:0] == C_FRAC_ALL1);
    assign w_b_nan   = (b[14:9] == C_EXP_ALL1) && (b[8:0] == C_FRAC_ALL1);
    assign w_sign_in = a[15] ^ b[15];
    assign w_accept  = in_valid && r_in_ready;
    assign w_bypass  = w_a_zero || w_b_zero || w_a_nan || w_b_nan;

    // One restoring step: subtract if the remainder covers the divisor,
    // then shift. Both branches leave a value below mb, so bit 10 is free
    // for the shift and the remainder never needs a 12th bit.
    logic        w_ge;
    logic [10:0] w_sub;
    logic [10:0] w_rem_next;
    logic [10:0] w_quo_next;

    assign w_ge       = (r_rem >= {1'b0, r_mb});
    assign w_sub      = r_rem - {1'b0, r_mb};
    assign w_rem_next = w_ge ? {w_sub[9:0], 1'b0} : {r_rem[9:0], 1'b0};
    assign w_quo_next = {r_quo[9:0], w_ge};

    // Normalisation: quotient is in [512, 2047]; bit 10 decides whether the
    // leading one sits one position higher (adds one to the exponent).
    logic signed [7:0] w_exp;
    logic [8:0]        w_frac;
    logic              w_ovf;
    logic              w_unf;

    assign w_exp  = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                  + (r_quo[10] ? 8'sd31 : 8'sd30);
    assign w_frac = r_quo[10] ? r_quo[9:1] : r_quo[8:0];
    assign w_ovf  = (w_exp > C_EXP_HI);
    assign w_unf  = (w_exp < C_EXP_LO);

    // Control FSM, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rem       <= 11'd0;
            r_quo       <= 11'd0;
            r_mb        <= 10'd0;
            r_ea        <= 6'd0;
            r_eb        <= 6'd0;
            r_sign      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 16'h0000;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_dz        <= 1'b0;
            r_nan       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= w_sign_in;
                        r_ea       <= a[14:9];
                        r_eb       <= b[14:9];
                        r_mb       <= {1'b1, b[8:0]};
                        r_rem      <= {2'b01, a[8:0]};
                        r_quo      <= 11'd0;
                        r_cnt      <= 4'd0;
                        if (w_bypass) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            // NaN dominates, then divide-by-zero, then zero dividend
                            if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero)) begin
                                r_result <= C_NAN;
                                r_nan    <= 1'b1;
                            end else if (w_b_zero) begin
                                r_result <= C_NAN;
                                r_dz     <= 1'b1;
                            end else begin
                                r_result <= {w_sign_in, 15'd0};
                            end
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (r_cnt == C_LAST_STEP) begin
                        r_state <= S_NORM;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_NORM: begin
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                    if (w_ovf) begin
                        r_result <= {r_sign, C_MAX_MAG};
                        r_ovf    <= 1'b1;
                    end else if (w_unf) begin
                        r_result <= {r_sign, 15'd0};
                        r_unf    <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_exp[5:0], w_frac};
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_result    <= 16'h0000;
                        r_ovf       <= 1'b0;
                        r_unf       <= 1'b0;
                        r_dz        <= 1'b0;
                        r_nan       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_ovf  = r_ovf;
    assign flag_unf  = r_unf;
    assign flag_dz   = r_dz;
    assign flag_nan  = r_nan;

endmodule
`default_nettype wire

// File: tb/tb_dlfloat16_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlfloat16_seq_div
// Brief    : Scoreboard bench for dlfloat16_seq_div: expected results come
//            from an integer reference model and are queued at stimulus time.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dlfloat16_seq_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_dz;
    logic        flag_nan;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;   // {ovf, unf, dz, nan}
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    dlfloat16_seq_div u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_dz   (flag_dz),
        .flag_nan  (flag_nan)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: direct integer quotient, not a bit-serial loop
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        exp_t r;
        int ex, ey, mx, my, q, e, fr;
        logic zx, zy, nx, ny, s;
        ex = int'(x[14:9]);
        ey = int'(y[14:9]);
        zx = (ex == 0);
        zy = (ey == 0);
        nx = (ex == 63) && (x[8:0] == 9'h1FF);
        ny = (ey == 63) && (y[8:0] == 9'h1FF);
        s  = x[15] ^ y[15];
        r.flags = 4'b0000;
        r.lat   = 1;
        if (nx || ny || (zx && zy)) begin
            r.res = 16'h7FFF; r.flags = 4'b0001;
        end else if (zy) begin
            r.res = 16'h7FFF; r.flags = 4'b0010;
        end else if (zx) begin
            r.res = {s, 15'd0};
        end else begin
            r.lat = 13;
            mx = 512 + int'(x[8:0]);
            my = 512 + int'(y[8:0]);
            q  = (mx * 1024) / my;
            if (q >= 1024) begin
                fr = (q / 2) % 512;
                e  = ex - ey + 31;
            end else begin
                fr = q % 512;
                e  = ex - ey + 30;
            end
            if (e > 62) begin
                r.res = {s, 15'h7DFF}; r.flags = 4'b1000;
            end else if (e < 1) begin
                r.res = {s, 15'd0}; r.flags = 4'b0100;
            end else begin
                r.res = {s, e[5:0], fr[8:0]};
            end
        end
        return r;
    endfunction

    // Offer one pair, check result, latency, optional backpressure
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input int stall);
        exp_t e;
        int   lat;
        @(negedge clk);
        check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        if (stall > 0) out_ready = 1'b0;
        sb_q.push_back(model(op_a, op_b));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        check_val("out_valid_seen", {31'd0, out_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("result", {16'd0, result}, {16'd0, e.res});
            check_val("flags", {28'd0, flag_ovf, flag_unf, flag_dz, flag_nan}, {28'd0, e.flags});
            check_val("latency", lat, e.lat);
            for (int i = 0; i < stall; i++) begin
                if (i == 1) begin
                    a = 16'h4100;
                    b = 16'h4000;
                    in_valid = 1'b1;
                end
                @(negedge clk);
                in_valid = 1'b0;
                check_val("stall_result", {16'd0, result}, {16'd0, e.res});
                check_val("stall_valid", {31'd0, out_valid}, 32'd1);
                check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_val("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check_val("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("post_hs_flags", {28'd0, flag_ovf, flag_unf, flag_dz, flag_nan}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [15:0] ra, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 16'h0000;
        b = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_result", {16'd0, result}, 32'd0);
        check_val("rst_flags", {28'd0, flag_ovf, flag_unf, flag_dz, flag_nan}, 32'd0);
        rst = 1'b0;

        // Directed cases
        run_op(16'h3E00, 16'h3E00, 0);   // 1.0 / 1.0
        run_op(16'h4100, 16'h4000, 0);   // 3.0 / 2.0
        run_op(16'hBE00, 16'h3E00, 0);   // -1.0 / 1.0
        run_op(16'hC100, 16'h4000, 0);   // -3.0 / 2.0
        run_op(16'h3E00, 16'h4100, 0);   // 1.0 / 3.0 (truncated)
        run_op(16'h3E00, 16'h0000, 0);   // divide by zero
        run_op(16'h0000, 16'h0000, 0);   // 0/0
        run_op(16'h8000, 16'h3E00, 0);   // -0 / 1.0
        run_op(16'h7FFF, 16'h3E00, 0);   // NaN dividend
        run_op(16'h3E00, 16'hFFFF, 0);   // NaN divisor (sign set)
        run_op(16'h7DFF, 16'h0200, 0);   // overflow
        run_op(16'h0200, 16'h7DFF, 0);   // underflow
        run_op(16'hFDFF, 16'h0200, 0);   // negative overflow

        // Backpressure with an ignored second offer
        run_op(16'h4100, 16'h4000, 5);
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_val("no_queued_op", seen, 0);

        // Reset during the 6th DIV cycle
        @(negedge clk);
        a = 16'h3E00;
        b = 16'h3E00;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_val("abort_hidden", seen, 0);
        run_op(16'h4100, 16'h4000, 0);

        // Random operand pairs
        for (int k = 0; k < 10; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, 0);
        end

        check_val("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
